// File: rtl/alu_exec_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared ALU.
interface alu_exec_arbiter_if;
  logic       req0, req1;
  logic       op0, op1;
  logic [7:0] a0, a1;
  logic [7:0] b0, b1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic [7:0] result;
  logic       busy;

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/alu_exec_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial ALU.
// MUL is shift-and-add, one multiplier bit per cycle (8 steps).
// SHIFT moves one bit position per cycle for B[3:0] steps.
module alu_exec_arbiter #(
  parameter int FIRST_PRIO = 0
) (
  input  logic               clk,
  input  logic               resetn,
  alu_exec_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_t     state, state_nx;

  // captured transaction
  logic       idx_r;
  logic       op_r;
  logic [1:0] typ_r;
  logic [3:0] amt_r;
  logic       sign_r;
  logic [7:0] opa;     // multiplicand (shifted left each step) or shift data
  logic [7:0] opb;     // multiplier (shifted right each step)
  logic [7:0] acc;
  logic [3:0] cnt;
  logic       last;    // index granted most recently

  // registered outputs
  logic       gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [7:0] result_q;

  // combinational decode
  logic       any_req, pick, sel_op;
  logic [7:0] sel_a, sel_b;
  logic       zero_shift, last_step;
  logic [7:0] acc_nx, sh_nx;

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

  // arbitration pick and operand mux for the IDLE accept edge
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick    = 1'b0;
    if (bus.req0 && bus.req1) pick = ~last;
    else if (bus.req1)        pick = 1'b1;
    sel_op     = pick ? bus.op1 : bus.op0;
    sel_a      = pick ? bus.a1  : bus.a0;
    sel_b      = pick ? bus.b1  : bus.b0;
    zero_shift = sel_op && (sel_b[3:0] == 4'd0);
  end

  // one ALU step: shift-and-add accumulate, or single-position shift
  always_comb begin
    acc_nx    = acc + (opb[0] ? opa : 8'h00);
    sh_nx     = opa;
    unique case (typ_r)
      2'b00: sh_nx = {opa[6:0], 1'b0};
      2'b01: sh_nx = {1'b0, opa[7:1]};
      2'b10: sh_nx = {sign_r, opa[7:1]};
      2'b11: sh_nx = {opa[0], opa[7:1]};
    endcase
    last_step = (cnt == (op_r ? (amt_r - 4'd1) : 4'd7));
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_req) state_nx = zero_shift ? DONE : EXEC;
      EXEC: if (last_step) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // datapath, arbitration pointer and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_r    <= 1'b0;
      op_r     <= 1'b0;
      typ_r    <= 2'b00;
      amt_r    <= 4'd0;
      sign_r   <= 1'b0;
      opa      <= 8'h00;
      opb      <= 8'h00;
      acc      <= 8'h00;
      cnt      <= 4'd0;
      last     <= LAST_RST;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= 8'h00;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= (state_nx != IDLE);
      unique case (state)
        IDLE: if (any_req) begin
          idx_r  <= pick;
          op_r   <= sel_op;
          typ_r  <= sel_b[5:4];
          amt_r  <= sel_b[3:0];
          sign_r <= sel_a[7];
          opa    <= sel_a;
          opb    <= sel_b;
          acc    <= 8'h00;
          cnt    <= 4'd0;
          last   <= pick;
          gnt0_q <= ~pick;
          gnt1_q <= pick;
          // zero-amount shift completes on the accept edge itself
          if (zero_shift) begin
            done0_q  <= ~pick;
            done1_q  <= pick;
            result_q <= sel_a;
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (op_r) begin
            opa <= sh_nx;
          end else begin
            acc <= acc_nx;
            opa <= {opa[6:0], 1'b0};
            opb <= {1'b0, opb[7:1]};
          end
          if (last_step) begin
            done0_q  <= ~idx_r;
            done1_q  <= idx_r;
            result_q <= op_r ? sh_nx : acc_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_arbiter.md
ALU_EXEC_ARBITER -- requirements
Module: alu_exec_arbiter

Interface
REQ-001 Parameter FIRST_PRIO, default 0: requester index (0 or 1) granted first when both request after reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESETN  input  1  asynchronous, active-low reset.
REQ-004 REQ0 / REQ1  input  1 each  operation request from requester 0 / 1; level, held until matching GNT.
REQ-005 OP0 / OP1  input  1 each  operation select: 0 = MUL, 1 = SHIFT.
REQ-006 A0 / A1  input  8 each  first operand (multiplicand / data to shift).
REQ-007 B0 / B1  input  8 each  second operand (multiplier / shift control: [5:4] type, [3:0] amount, [7:6] ignored).
REQ-008 GNT0 / GNT1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-009 DONE0 / DONE1  output  1 each  one-cycle pulse: RESULT valid for that requester.
REQ-010 RESULT  output  8  result of the last completed operation.
REQ-011 BUSY  output  1  high while an operation is in flight (EXEC or DONE state).

Function
REQ-012 FSM states: IDLE, EXEC, DONE; all outputs registered.
REQ-013 IDLE, at an edge E0 with any REQ high: select a requester, latch its OP/A/B and index, assert its GNT for the one cycle after E0, clear step counter.
REQ-014 Arbitration: one request -> grant it; both -> grant the one not granted last (round-robin); the last-granted pointer resets so that FIRST_PRIO wins first.
REQ-015 Operand changes after E0 have no effect; the non-granted REQ stays pending, and no GNT occurs outside IDLE.
REQ-016 MUL: shift-and-add, one multiplier bit per EXEC cycle, 8 steps; RESULT = lower 8 bits of A*B (identical for signed and unsigned).
REQ-017 SHIFT: one bit position per EXEC cycle for B[3:0] steps; types 00 SLL (zero fill), 01 SRL (zero fill), 10 SRA (fill with the A[7] captured at E0), 11 ROR.
REQ-018 Amounts 8-15 are iterated fully: SLL/SRL yield 0x00, SRA yields all-sign, ROR yields rotate by amount mod 8.
REQ-019 SHIFT with amount 0: E0 goes directly to DONE; DONE and GNT are asserted in the same cycle; RESULT = A.
REQ-020 EXEC -> DONE at the edge completing the last step; MUL DONE is asserted 8 cycles after GNT; SHIFT DONE is asserted B[3:0] cycles after GNT.
REQ-021 DONE state lasts one cycle: DONEx pulses for the granted index, RESULT is updated, then -> IDLE; the next grant occurs no earlier than the edge after DONE.
REQ-022 RESULT holds its value until the next DONE; GNTx and DONEx are never high for both indices in the same cycle.
REQ-023 BUSY is low in IDLE and high in EXEC and DONE.

Reset
REQ-024 RESETN low -> immediately: state IDLE; GNT0, GNT1, DONE0, DONE1, BUSY = 0; RESULT = 0x00; counter and latched operands cleared; last-granted pointer = 1-FIRST_PRIO.
REQ-025 Reset mid-operation aborts it without a DONE pulse; after release, the first rising edge with a REQ high starts a fresh grant.

Verification
REQ-026 REQ0, OP0=0, A0=0x07, B0=0x06 -> GNT0 pulse, DONE0 8 cycles later, RESULT=0x2A, BUSY high from the GNT cycle through the DONE cycle.
REQ-027 REQ1 MUL A1=0xFD, B1=0x05 -> DONE1 with RESULT=0xF1; A1 changed to 0x00 after GNT1 -> RESULT unchanged.
REQ-028 Shifts: A=0x90, B=0x23 -> 0xF2 after 3 cycles; A=0x81, B=0x31 -> 0xC0; A=0xFF, B=0x0C -> 0x00 after 12 cycles; A=0x5A, B=0x10 -> GNT and DONE in the same cycle, RESULT=0x5A.
REQ-029 REQ0 and REQ1 held high continuously (FIRST_PRIO=0) -> grant order 0,1,0,1; never two GNTs or DONEs in one cycle.
REQ-030 RESETN low 4 cycles into a MUL -> all outputs 0 asynchronously, no DONE; after release, REQ0 MUL 0x03*0x03 -> RESULT=0x09.
